// File: rtl/upsample_nn.sv
// Nearest-neighbour upsampler: ping-pong line buffer, each line replayed SCALE x SCALE.
// Optional sticky drop indicator overflow_o when UPSAMPLE_OVF_EN is defined.
module upsample_nn #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned CHANNEL_NUM = 3,
  parameter int unsigned STRING_LEN  = 4,
  parameter int unsigned SCALE       = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
`ifdef UPSAMPLE_OVF_EN
  output logic                         overflow_o,
`endif
  input  logic                         sop_i,
  input  logic                         eop_i,
  input  logic                         sof_i,
  input  logic                         eof_i,
  input  logic                         valid_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         data_valid_o,
  output logic                         sop_o,
  output logic                         eop_o,
  output logic                         sof_o,
  output logic                         eof_o
);

  localparam int unsigned LineW = CHANNEL_NUM * STRING_LEN;
  localparam int unsigned AW    = (LineW > 1) ? $clog2(LineW) : 1;
  localparam int unsigned PW    = $clog2(LineW + 1);
  localparam int unsigned ChW   = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int unsigned PixW  = (STRING_LEN > 1) ? $clog2(STRING_LEN) : 1;
  localparam int unsigned RepW  = $clog2(SCALE);

  localparam logic [PW-1:0]   LineWP = PW'(LineW);
  localparam logic [ChW-1:0]  ChMax  = ChW'(CHANNEL_NUM - 1);
  localparam logic [PixW-1:0] PixMax = PixW'(STRING_LEN - 1);
  localparam logic [RepW-1:0] RepMax = RepW'(SCALE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StLast} state_e;

  logic signed [DATA_WIDTH-1:0] mem_q [2][LineW];
  logic signed [DATA_WIDTH-1:0] rd_data_q;

  logic          wr_bank_q, wr_bank_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          wr_active_q, wr_active_d;
  logic          wr_sof_q, wr_sof_d;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          commit;

  logic [1:0] full_q, full_d, full_avail;
  logic [1:0] sof_tag_q, eof_tag_q;

  state_e          state_q, state_d;
  logic            rd_bank_q, rd_bank_d;
  logic [ChW-1:0]  ch_q, ch_d;
  logic [RepW-1:0] hrep_q, hrep_d;
  logic [PixW-1:0] pix_q, pix_d;
  logic [RepW-1:0] vrep_q, vrep_d;
  logic            issue, rd_clear;
  logic [AW-1:0]   rd_addr;

  logic v1_q, sop1_q, eop1_q, sof1_q, eof1_q;
  logic sop1_d, eop1_d, sof1_d, eof1_d;

  // Write side: a sop_i that finds its bank still full discards the whole line.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_ptr_d    = wr_ptr_q;
    wr_active_d = wr_active_q;
    wr_sof_d    = wr_sof_q;
    mem_we      = 1'b0;
    mem_waddr   = AW'(wr_ptr_q);
    commit      = 1'b0;
    if (valid_i) begin
      if (sop_i) begin
        if (full_q[wr_bank_q]) begin
          wr_active_d = 1'b0;
        end else begin
          wr_active_d = 1'b1;
          mem_we      = 1'b1;
          mem_waddr   = '0;
          wr_ptr_d    = PW'(1);
          wr_sof_d    = sof_i;
        end
      end else if (wr_active_q && (wr_ptr_q < LineWP)) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (eop_i && wr_active_d) begin
        commit      = 1'b1;
        wr_active_d = 1'b0;
        wr_bank_d   = ~wr_bank_q;
      end
    end
  end

  always_comb begin
    full_d = full_q;
    if (rd_clear) full_d[rd_bank_q] = 1'b0;
    if (commit)   full_d[wr_bank_q] = 1'b1;
  end

  // Lets the reader start on a bank in the very cycle it is committed.
  assign full_avail = full_q | ({1'b0, commit} << wr_bank_q);

  // LAST issues the final word so back-to-back replays run without a gap.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    ch_d      = ch_q;
    hrep_d    = hrep_q;
    pix_d     = pix_q;
    vrep_d    = vrep_q;
    issue     = 1'b0;
    rd_clear  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (full_avail[rd_bank_q]) state_d = StRun;
      end
      StRun: begin
        issue = 1'b1;
        if (ch_q != ChMax) begin
          ch_d = ch_q + 1'b1;
        end else begin
          ch_d = '0;
          if (hrep_q != RepMax) begin
            hrep_d = hrep_q + 1'b1;
          end else begin
            hrep_d = '0;
            if (pix_q != PixMax) begin
              pix_d = pix_q + 1'b1;
            end else begin
              pix_d  = '0;
              vrep_d = vrep_q + 1'b1;
            end
          end
        end
        if ((ch_d == ChMax) && (hrep_d == RepMax) && (pix_d == PixMax) && (vrep_d == RepMax)) begin
          state_d = StLast;
        end
      end
      StLast: begin
        issue     = 1'b1;
        rd_clear  = 1'b1;
        rd_bank_d = ~rd_bank_q;
        ch_d      = '0;
        hrep_d    = '0;
        pix_d     = '0;
        vrep_d    = '0;
        state_d   = full_avail[~rd_bank_q] ? StRun : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_addr = AW'(pix_q * CHANNEL_NUM + ch_q);

  always_comb begin
    sop1_d = issue && (ch_q == '0) && (hrep_q == '0) && (pix_q == '0);
    eop1_d = issue && (ch_q == ChMax) && (hrep_q == RepMax) && (pix_q == PixMax);
    sof1_d = sop1_d && (vrep_q == '0) && sof_tag_q[rd_bank_q];
    eof1_d = eop1_d && (vrep_q == RepMax) && eof_tag_q[rd_bank_q];
  end

  // Storage is never reset; full flags gate every read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_bank_q][mem_waddr] <= data_i;
    rd_data_q <= mem_q[rd_bank_q][rd_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank_q    <= 1'b0;
      wr_ptr_q     <= '0;
      wr_active_q  <= 1'b0;
      wr_sof_q     <= 1'b0;
      full_q       <= '0;
      sof_tag_q    <= '0;
      eof_tag_q    <= '0;
      state_q      <= StIdle;
      rd_bank_q    <= 1'b0;
      ch_q         <= '0;
      hrep_q       <= '0;
      pix_q        <= '0;
      vrep_q       <= '0;
      v1_q         <= 1'b0;
      sop1_q       <= 1'b0;
      eop1_q       <= 1'b0;
      sof1_q       <= 1'b0;
      eof1_q       <= 1'b0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      sop_o        <= 1'b0;
      eop_o        <= 1'b0;
      sof_o        <= 1'b0;
      eof_o        <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_active_q <= wr_active_d;
      wr_sof_q    <= wr_sof_d;
      full_q      <= full_d;
      if (commit) begin
        sof_tag_q[wr_bank_q] <= wr_sof_d;
        eof_tag_q[wr_bank_q] <= eof_i;
      end
      state_q      <= state_d;
      rd_bank_q    <= rd_bank_d;
      ch_q         <= ch_d;
      hrep_q       <= hrep_d;
      pix_q        <= pix_d;
      vrep_q       <= vrep_d;
      v1_q         <= issue;
      sop1_q       <= sop1_d;
      eop1_q       <= eop1_d;
      sof1_q       <= sof1_d;
      eof1_q       <= eof1_d;
      data_o       <= v1_q ? rd_data_q : '0;
      data_valid_o <= v1_q;
      sop_o        <= sop1_q;
      eop_o        <= eop1_q;
      sof_o        <= sof1_q;
      eof_o        <= eof1_q;
    end
  end

`ifdef UPSAMPLE_OVF_EN
  logic ovf_q;
  logic drop, sof_accept;

  assign drop       = valid_i && sop_i && full_q[wr_bank_q];
  assign sof_accept = valid_i && sop_i && !full_q[wr_bank_q] && sof_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (sof_accept) begin
      ovf_q <= 1'b0;
    end
  end

  assign overflow_o = ovf_q;
`endif

endmodule

// File: tb/tb_upsample_nn.sv
// Directed bench for upsample_nn (CHANNEL_NUM=3, STRING_LEN=4, SCALE=2).
module tb_upsample_nn;

  typedef logic signed [7:0] line_t [12];
  typedef struct {
    logic signed [7:0] d;
    logic [3:0]        fl;
    int                cyc;
  } word_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sop_i = 1'b0, eop_i = 1'b0, sof_i = 1'b0, eof_i = 1'b0, valid_i = 1'b0;
  logic signed [7:0] data_i = '0;
  logic signed [7:0] data_o;
  logic data_valid_o, sop_o, eop_o, sof_o, eof_o;
`ifdef UPSAMPLE_OVF_EN
  logic overflow;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  word_t q[$];

  // Read order for one 24-word vrep pass, as indices into the stored line.
  int exp_idx [24] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5,
                       6, 7, 8, 6, 7, 8, 9, 10, 11, 9, 10, 11};

  upsample_nn dut (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef UPSAMPLE_OVF_EN
    .overflow_o   (overflow),
`endif
    .sop_i        (sop_i),
    .eop_i        (eop_i),
    .sof_i        (sof_i),
    .eof_i        (eof_i),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .sop_o        (sop_o),
    .eop_o        (eop_o),
    .sof_o        (sof_o),
    .eof_o        (eof_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid_o) q.push_back('{d: data_o, fl: {sop_o, eop_o, sof_o, eof_o}, cyc: cyc});
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic signed [7:0] d, input logic sop, input logic eop,
                           input logic sof, input logic eof);
    data_i  = d;
    sop_i   = sop;
    eop_i   = eop;
    sof_i   = sof;
    eof_i   = eof;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input line_t ln, input logic sof, input logic eof, output int eop_cyc);
    eop_cyc = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 11) eop_cyc = cyc;
      send_word(ln[k], k == 0, k == 11, sof && (k == 0), eof && (k == 11));
    end
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    sop_i   = 1'b0;
    eop_i   = 1'b0;
    sof_i   = 1'b0;
    eof_i   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input string tag, input int n);
    int t;
    t = 0;
    while (q.size() < n && t < 400) begin
      @(posedge clk);
      t++;
    end
    repeat (8) @(posedge clk);
    #1;
    check({tag, " count"}, q.size(), n);
    if (q.size() >= n && n > 0) check({tag, " span"}, q[n-1].cyc - q[0].cyc, n - 1);
  endtask

  task automatic verify_line(input string tag, input line_t ln, input logic sof, input logic eof,
                             input int base);
    logic [3:0] efl;
    for (int i = 0; i < 48 && base + i < q.size(); i++) begin
      efl = {i % 24 == 0, i % 24 == 23, sof && i == 0, eof && i == 47};
      check($sformatf("%s data[%0d]", tag, i), int'(q[base+i].d), int'(ln[exp_idx[i%24]]));
      check($sformatf("%s flags[%0d]", tag, i), int'(q[base+i].fl), int'(efl));
    end
  endtask

  function automatic line_t ramp(input int base);
    line_t ln;
    for (int k = 0; k < 12; k++) ln[k] = 8'(base + k);
    return ln;
  endfunction

  function automatic int out_vec();
    return int'({data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o});
  endfunction

  initial begin
    line_t la, lb, lc, ld;
    int e0, e1, e2, sz;

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", out_vec(), 0);
`ifdef UPSAMPLE_OVF_EN
    check("reset overflow", int'(overflow), 0);
`endif
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single line, latency and flags
    la = ramp(0);
    send_line(la, 1'b1, 1'b1, e0);
    idle(1);
    wait_words("t1", 48);
    if (q.size() > 0) check("t1 latency", q[0].cyc - e0, 3);
    verify_line("t1", la, 1'b1, 1'b1, 0);
    q.delete();

    // 2: two lines back to back, no gap between replays
    la = ramp(0);
    lb = ramp(12);
    send_line(la, 1'b1, 1'b0, e0);
    send_line(lb, 1'b0, 1'b1, e1);
    idle(1);
    wait_words("t2", 96);
    verify_line("t2a", la, 1'b1, 1'b0, 0);
    verify_line("t2b", lb, 1'b0, 1'b1, 48);
    q.delete();

    // 3: third back-to-back line is dropped
    la = ramp(40);
    lb = ramp(52);
    lc = ramp(64);
    send_line(la, 1'b1, 1'b0, e0);
    send_line(lb, 1'b0, 1'b0, e1);
    send_line(lc, 1'b0, 1'b1, e2);
    idle(1);
`ifdef UPSAMPLE_OVF_EN
    check("t3 overflow set", int'(overflow), 1);
`endif
    wait_words("t3", 96);
    verify_line("t3a", la, 1'b1, 1'b0, 0);
    verify_line("t3b", lb, 1'b0, 1'b0, 48);
`ifdef UPSAMPLE_OVF_EN
    check("t3 overflow sticky", int'(overflow), 1);
`endif
    q.delete();
    ld = ramp(-20);
    send_line(ld, 1'b1, 1'b1, e0);
    idle(1);
`ifdef UPSAMPLE_OVF_EN
    check("t3 overflow cleared", int'(overflow), 0);
`endif
    wait_words("t3d", 48);
    verify_line("t3d", ld, 1'b1, 1'b1, 0);
    q.delete();

    // 4: signed extremes pass through untouched
    la = '{-128, 127, -1, -2, -3, -4, 5, 6, 7, -100, 100, 0};
    send_line(la, 1'b1, 1'b1, e0);
    idle(1);
    wait_words("t4", 48);
    verify_line("t4", la, 1'b1, 1'b1, 0);
    q.delete();

    // 5: truncated line restarted by a new sop
    for (int k = 0; k < 5; k++) send_word(8'(90 + k), k == 0, 1'b0, k == 0, 1'b0);
    la = ramp(20);
    send_line(la, 1'b1, 1'b1, e0);
    idle(1);
    wait_words("t5", 48);
    verify_line("t5", la, 1'b1, 1'b1, 0);
    q.delete();

    // 6: reset during replay
    la = ramp(50);
    send_line(la, 1'b1, 1'b1, e0);
    idle(0);
    sz = 0;
    while (q.size() < 31 && sz < 200) begin
      @(posedge clk);
      sz++;
    end
    check("t6 reached word 30", int'(q.size() >= 31), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6 outputs zero", out_vec(), 0);
    @(posedge clk);
    #1;
    check("t6 outputs held zero", out_vec(), 0);
    reset_n = 1'b1;
    sz = q.size();
    idle(60);
    check("t6 no words after reset", q.size(), sz);
    q.delete();
    lb = ramp(70);
    send_line(lb, 1'b1, 1'b1, e0);
    idle(1);
    wait_words("t6", 48);
    if (q.size() > 0) check("t6 latency", q[0].cyc - e0, 3);
    verify_line("t6", lb, 1'b1, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
